// File: rtl/h264dc_pkg.sv
// Shared types and helpers for the luma DC collection buffer.
//   DC_W      : width of one signed DC coefficient
//   dc_coef_t : one DC coefficient
//   dc_row_t  : one raster row of four coefficients, lane 0 = column 0
//   blk2xy    : maps a 4x4-block scan index to its raster position {y,x}
package h264dc_pkg;

   localparam int DC_W = 16;

   typedef logic signed [DC_W-1:0] dc_coef_t;
   typedef dc_coef_t dc_row_t [4];

   // Block scan order walks 8x8 quadrants in Z order and 4x4 blocks inside
   // each quadrant in Z order, so the index bits interleave as y1 x1 y0 x0.
   function automatic logic [3:0] blk2xy(input logic [3:0] n);
      return {n[3], n[1], n[2], n[0]};
   endfunction

endpackage

// File: rtl/h264dc_collect_bank.sv
// One 4x4 bank of DC coefficients.
//   CLK, RESET      : clock, asynchronous active-low reset (clears storage)
//   wr_en           : write one coefficient this cycle
//   wr_x, wr_y      : raster column / row of the write
//   wr_data         : coefficient to store
//   rd_row          : raster row to present
//   rd_data         : four lanes of rd_row, lane c = rd_data[DW*c +: DW]
module h264dc_collect_bank
   import h264dc_pkg::*;
#(
   parameter int DW = DC_W
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            wr_en,
   input  logic [1:0]      wr_x,
   input  logic [1:0]      wr_y,
   input  logic [DW-1:0]   wr_data,
   input  logic [1:0]      rd_row,
   output logic [4*DW-1:0] rd_data
);

   logic [DW-1:0] mem [4][4];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mem <= '{default: '0};
      end else if (wr_en) begin
         mem[wr_y][wr_x] <= wr_data;
      end
   end

   assign rd_data = {mem[rd_row][3], mem[rd_row][2], mem[rd_row][1], mem[rd_row][0]};

endmodule

// File: rtl/h264dc_collect_buffer.sv
// Ping-pong collector for the 16 luma DC coefficients of a macroblock.
// Coefficients arrive in 4x4-block scan order and leave as raster rows.
//   CLK, RESET   : clock, asynchronous active-low reset
//   DCIN         : signed DC coefficient of the current 4x4 block
//   DCIN_VALID   : DCIN valid
//   DCIN_READY   : the bank being filled is free
//   DCOUT        : one raster row, lane c = DCOUT[DW*c +: DW]
//   DCOUT_ROW    : row index of DCOUT
//   DCOUT_VALID  : a full bank is being drained
//   DCOUT_LAST   : last row of the macroblock
//   DCOUT_READY  : downstream accepts the current row
module h264dc_collect_buffer
   import h264dc_pkg::*;
#(
   parameter int DW = DC_W
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [DW-1:0]   DCIN,
   input  logic            DCIN_VALID,
   output logic            DCIN_READY,
   output logic [4*DW-1:0] DCOUT,
   output logic [1:0]      DCOUT_ROW,
   output logic            DCOUT_VALID,
   output logic            DCOUT_LAST,
   input  logic            DCOUT_READY
);

   logic [1:0]      full;
   logic [1:0]      full_nxt;
   logic            wr_bank;
   logic [3:0]      wr_cnt;
   logic            rd_bank;
   logic [1:0]      rd_row;
   logic            wr_fire;
   logic            rd_fire;
   logic [3:0]      wr_yx;
   logic [4*DW-1:0] bank_row [2];

   assign DCIN_READY  = !full[wr_bank];
   assign DCOUT_VALID = full[rd_bank];
   assign DCOUT       = bank_row[rd_bank];
   assign DCOUT_ROW   = rd_row;
   assign DCOUT_LAST  = DCOUT_VALID && (rd_row == 2'd3);

   assign wr_fire = DCIN_VALID && DCIN_READY;
   assign rd_fire = DCOUT_VALID && DCOUT_READY;
   assign wr_yx   = blk2xy(wr_cnt);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      h264dc_collect_bank #(.DW(DW)) u_bank (
         .CLK     (CLK),
         .RESET   (RESET),
         .wr_en   (wr_fire && (int'(wr_bank) == b)),
         .wr_x    (wr_yx[1:0]),
         .wr_y    (wr_yx[3:2]),
         .wr_data (DCIN),
         .rd_row  (rd_row),
         .rd_data (bank_row[b])
      );
   end

   // Set and clear can coincide only on different banks, so both apply.
   always_comb begin
      full_nxt = full;
      if (wr_fire && (wr_cnt == 4'd15)) full_nxt[wr_bank] = 1'b1;
      if (rd_fire && (rd_row == 2'd3))  full_nxt[rd_bank] = 1'b0;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         full    <= '0;
         wr_bank <= 1'b0;
         wr_cnt  <= '0;
         rd_bank <= 1'b0;
         rd_row  <= '0;
      end else begin
         full <= full_nxt;
         if (wr_fire) begin
            wr_cnt <= wr_cnt + 4'd1;
            if (wr_cnt == 4'd15) wr_bank <= ~wr_bank;
         end
         if (rd_fire) begin
            rd_row <= rd_row + 2'd1;
            if (rd_row == 2'd3) rd_bank <= ~rd_bank;
         end
      end
   end

endmodule

// File: tb/tb_h264dc_collect_buffer.sv
module tb_h264dc_collect_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] dcin = '0;
   logic        dcin_valid = 1'b0;
   logic        dcin_ready;
   logic [63:0] dcout;
   logic [1:0]  dcout_row;
   logic        dcout_valid;
   logic        dcout_last;
   logic        dcout_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   h264dc_collect_buffer #(.DW(16)) dut (
      .CLK         (clk),
      .RESET       (rst_n),
      .DCIN        (dcin),
      .DCIN_VALID  (dcin_valid),
      .DCIN_READY  (dcin_ready),
      .DCOUT       (dcout),
      .DCOUT_ROW   (dcout_row),
      .DCOUT_VALID (dcout_valid),
      .DCOUT_LAST  (dcout_last),
      .DCOUT_READY (dcout_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] coll [16];       // raster-ordered partial macroblock
   int          coll_n = 0;
   logic [63:0] exp_q [$];       // raster rows of complete macroblocks
   int          mb_count = 0;    // complete macroblocks not yet fully drained
   int          rd_beat = 0;
   int          in_acc = 0;

   always @(negedge clk) begin
      bit acc_in, acc_out;
      int n, q, s, x, y;
      if (!rst_n) begin
         coll_n = 0; exp_q.delete(); mb_count = 0; rd_beat = 0;
         chk("rst_dcin_ready", 64'(dcin_ready), 64'd1);
         chk("rst_valid", 64'(dcout_valid), 64'd0);
         chk("rst_last", 64'(dcout_last), 64'd0);
         chk("rst_row", 64'(dcout_row), 64'd0);
         chk("rst_dcout", dcout, 64'd0);
      end else begin
         chk("dcin_ready", 64'(dcin_ready), 64'(mb_count < 2));
         chk("dcout_valid", 64'(dcout_valid), 64'(mb_count > 0));
         if (mb_count > 0 && exp_q.size() > 0) begin
            chk("dcout_data", dcout, exp_q[0]);
            chk("dcout_row", 64'(dcout_row), 64'(rd_beat));
            chk("dcout_last", 64'(dcout_last), 64'(rd_beat == 3));
         end else begin
            chk("idle_last", 64'(dcout_last), 64'd0);
         end
         acc_in  = dcin_valid && (mb_count < 2);
         acc_out = (mb_count > 0) && dcout_ready;
         if (acc_out) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat @%0t: got beat expected none", $time);
            end else begin
               void'(exp_q.pop_front());
            end
            if (rd_beat == 3) begin
               rd_beat = 0;
               mb_count--;
            end else begin
               rd_beat++;
            end
         end
         if (acc_in) begin
            in_acc++;
            n = coll_n;
            q = n / 4; s = n % 4;
            x = (q % 2) * 2 + (s % 2);
            y = (q / 2) * 2 + (s / 2);
            coll[y * 4 + x] = dcin;
            coll_n++;
            if (coll_n == 16) begin
               for (int r = 0; r < 4; r++)
                  exp_q.push_back({coll[r*4+3], coll[r*4+2], coll[r*4+1], coll[r*4]});
               coll_n = 0;
               mb_count++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [15:0] tx_q [$];
   int          rdy_mode = 1;    // 0 hold low, 1 hold high, 2 toggle

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: dcout_ready = 1'b0;
            1: dcout_ready = 1'b1;
            default: dcout_ready = ~dcout_ready;
         endcase
      end
   end

   task automatic push_seq(input int base);
      for (int i = 0; i < 16; i++) tx_q.push_back(16'(base + i));
   endtask

   task automatic feed(input int n, input int gap);
      int i = 0, guard = 0;
      bit acc;
      while (i < n) begin
         if (gap > 0 && $urandom_range(99) < gap) begin
            dcin_valid = 1'b0;
            dcin = 16'($urandom);
         end else begin
            dcin_valid = 1'b1;
            dcin = tx_q[0];
         end
         @(negedge clk);
         acc = dcin_valid && dcin_ready;
         @(posedge clk); #1;
         if (acc) begin
            void'(tx_q.pop_front());
            i++;
         end
         guard++;
         if (guard > 2000) begin
            errors++;
            $display("FAIL feed_timeout @%0t: got %0d accepted expected %0d", $time, i, n);
            break;
         end
      end
      dcin_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int g = 0;
      while (mb_count != 0) begin
         @(posedge clk); #1;
         g++;
         if (g > 500) begin
            errors++;
            $display("FAIL drain_timeout @%0t: got %0d pending expected 0", $time, mb_count);
            break;
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pin_ramp(input string tag, input int base);
      chk({tag, "_r0"}, exp_q[0], {16'(base+5),  16'(base+4),  16'(base+1),  16'(base+0)});
      chk({tag, "_r1"}, exp_q[1], {16'(base+7),  16'(base+6),  16'(base+3),  16'(base+2)});
      chk({tag, "_r2"}, exp_q[2], {16'(base+13), 16'(base+12), 16'(base+9),  16'(base+8)});
      chk({tag, "_r3"}, exp_q[3], {16'(base+15), 16'(base+14), 16'(base+11), 16'(base+10)});
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tx_q.delete();
   endtask

   initial begin
      int start, g;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: ramp 0..15 back-to-back
      rdy_mode = 0;
      push_seq(0); feed(16, 0);
      pin_ramp("t1", 0);
      chk("t1_valid_after_16", 64'(dcout_valid), 64'd1);
      rdy_mode = 1;
      wait_empty();

      // 2: 48 values with downstream stalled
      rdy_mode = 0;
      start = in_acc;
      push_seq(16); push_seq(32); push_seq(48);
      fork feed(48, 0); join_none
      repeat (50) @(posedge clk);
      #1;
      chk("t2_accepted_before_stall", 64'(in_acc - start), 64'd32);
      chk("t2_dcin_ready_low", 64'(dcin_ready), 64'd0);
      rdy_mode = 1;
      wait fork;
      wait_empty();

      // 3: toggling downstream ready
      rdy_mode = 2;
      push_seq(300); push_seq(400);
      feed(32, 0);
      wait_empty();
      rdy_mode = 1;

      // 4: extreme values
      rdy_mode = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 0) tx_q.push_back(16'h8000);
         else if (i == 15) tx_q.push_back(16'h7fff);
         else if (i == 7) tx_q.push_back(16'hffff);
         else tx_q.push_back(16'(i));
      end
      feed(16, 0);
      chk("t4_x0y0", 64'(exp_q[0][15:0]), 64'h8000);
      chk("t4_x3y3", 64'(exp_q[3][63:48]), 64'h7fff);
      chk("t4_x3y1", 64'(exp_q[1][63:48]), 64'hffff);
      rdy_mode = 1;
      wait_empty();

      // 5a: reset mid-collection
      push_seq(500); feed(9, 0);
      pulse_reset();
      push_seq(100); feed(16, 0);
      pin_ramp("t5a", 100);
      wait_empty();

      // 5b: reset during row 2 of a drain
      rdy_mode = 0;
      push_seq(200); feed(16, 0);
      rdy_mode = 1;
      g = 0;
      while (!(dcout_valid && dcout_row == 2'd2) && g < 50) begin
         @(posedge clk); #1; g++;
      end
      chk("t5b_reached_row2", 64'(dcout_row), 64'd2);
      pulse_reset();
      push_seq(100); feed(16, 0);
      wait_empty();

      // 6: random input gaps
      push_seq(0); push_seq(0);
      rdy_mode = 0;
      feed(16, 30);
      pin_ramp("t6", 0);
      rdy_mode = 1;
      feed(16, 30);
      wait_empty();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
